// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if: digit data, masks and scan outputs between time-keeping logic and the display scanner
interface display_scan_ctrl_if #(
    parameter int NUM_DIGITS = 6
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic                    lz_en;
    logic [3:0]              bcd_out;
    logic [NUM_DIGITS-1:0]   anode_n;
    logic                    dp_n;
    logic                    frame_start;
    modport master (
        output digits_in, blank_mask, dp_mask, lz_en,
        input  bcd_out, anode_n, dp_n, frame_start
    );
    modport slave (
        input  digits_in, blank_mask, dp_mask, lz_en,
        output bcd_out, anode_n, dp_n, frame_start
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed common-anode 7-segment scanner with snapshot, blanking and leading-zero suppression
module display_scan_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int PRESCALE   = 50000,
    parameter int BLANK_CYC  = 500
) (
    input logic clk,
    input logic rst,
    display_scan_ctrl_if.slave bus
);
    localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] snap;
    logic                    run;
    logic                    ld;
    logic                    end_slot;
    logic                    end_frame;
    logic                    load;
    logic                    lit;
    logic                    z;
    logic [NUM_DIGITS-1:0]   sup;
    always_comb begin
        sup = '0;
        z = bus.lz_en;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            z = z && (snap[4*i +: 4] == 4'd0);
            sup[i] = z;
        end
    end
    // the first edge out of reset only captures a snapshot; the slot counter starts on the next one
    assign end_slot  = cnt == CW'(PRESCALE - 1);
    assign end_frame = end_slot && idx == IW'(NUM_DIGITS - 1);
    assign load      = !run || end_frame;
    assign lit       = run && cnt >= CW'(BLANK_CYC) && !bus.blank_mask[idx] && !sup[idx];
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt             <= '0;
            idx             <= '0;
            snap            <= '0;
            run             <= 1'b0;
            ld              <= 1'b0;
            bus.bcd_out     <= 4'd0;
            bus.anode_n     <= '1;
            bus.dp_n        <= 1'b1;
            bus.frame_start <= 1'b0;
        end else begin
            run             <= 1'b1;
            ld              <= load;
            bus.frame_start <= ld;
            if (load) snap <= bus.digits_in;
            if (run) cnt <= end_slot ? '0 : cnt + CW'(1);
            if (run && end_slot) idx <= end_frame ? '0 : idx + IW'(1);
            bus.bcd_out     <= snap[{idx, 2'b00} +: 4];
            bus.anode_n     <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
            bus.dp_n        <= ~(lit & bus.dp_mask[idx]);
        end
    end
endmodule
